// File: rtl/ire_pulse_sequencer.sv
// ire_pulse_sequencer: IRE session controller for the pulse-train trigger driver.
// It arms the driver, turns each trigger rising edge into one fixed-width HV
// pulse followed by a dead time, and counts pulses up to a target. It also
// faults when the wait for a trigger goes on too long.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_start, i_abort    one-cycle session start / abort (abort also clears FAULT)
//   i_trig              driver done (level or pulse, edge-detected here)
//   i_cfg_target        pulses per session
//   i_cfg_pw            pulse width in cycles
//   i_cfg_dead          dead time in cycles
//   i_cfg_timeout       trigger-wait limit in cycles, 0 = no limit
//   o_drv_en            trigger driver enable
//   o_pulse_out         HV pulse gate
//   o_busy              session active
//   o_session_done      one-cycle pulse on normal completion
//   o_cfg_err           one-cycle pulse when start is rejected
//   o_err_timeout       high while faulted
//   o_pulses_sent       pulses delivered in the current/last session
//   o_missed_trig       triggers ignored during pulse/dead time (saturating)
module ire_pulse_sequencer #(
    parameter int CNT_W = 10,
    parameter int PW_W  = 16,
    parameter int TO_W  = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic             i_trig,
    input  logic [CNT_W-1:0] i_cfg_target,
    input  logic [PW_W-1:0]  i_cfg_pw,
    input  logic [PW_W-1:0]  i_cfg_dead,
    input  logic [TO_W-1:0]  i_cfg_timeout,
    output logic             o_drv_en,
    output logic             o_pulse_out,
    output logic             o_busy,
    output logic             o_session_done,
    output logic             o_cfg_err,
    output logic             o_err_timeout,
    output logic [CNT_W-1:0] o_pulses_sent,
    output logic [7:0]       o_missed_trig
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_WAIT,
        S_PULSE,
        S_DEAD,
        S_DONE,
        S_FAULT
    } state_t;

    state_t           r_state;
    logic             r_trig_q;
    logic [CNT_W-1:0] r_target;
    logic [PW_W-1:0]  r_pw;
    logic [PW_W-1:0]  r_dead;
    logic [TO_W-1:0]  r_timeout;
    logic [PW_W-1:0]  r_cnt;
    logic [TO_W-1:0]  r_to_cnt;
    logic [CNT_W-1:0] r_pulses;
    logic [7:0]       r_missed;

    state_t           w_nxt_state;
    logic [CNT_W-1:0] w_nxt_target;
    logic [PW_W-1:0]  w_nxt_pw;
    logic [PW_W-1:0]  w_nxt_dead;
    logic [TO_W-1:0]  w_nxt_timeout;
    logic [PW_W-1:0]  w_nxt_cnt;
    logic [TO_W-1:0]  w_nxt_to_cnt;
    logic [CNT_W-1:0] w_nxt_pulses;
    logic [7:0]       w_nxt_missed;
    logic             w_cfg_err;
    logic             w_rise;
    logic             w_cfg_ok;
    logic [CNT_W-1:0] w_pulses_inc;
    logic [TO_W-1:0]  w_to_inc;
    logic [PW_W-1:0]  w_cnt_inc;
    logic [7:0]       w_missed_inc;
    logic             w_nxt_busy;

    assign w_rise       = i_trig & ~r_trig_q;
    assign w_cfg_ok     = (i_cfg_target != '0) && (i_cfg_pw != '0);
    assign w_pulses_inc = r_pulses + 1'b1;
    assign w_to_inc     = r_to_cnt + 1'b1;
    assign w_cnt_inc    = r_cnt + 1'b1;
    // Missed-trigger count sticks at 255 instead of wrapping.
    assign w_missed_inc = (r_missed == 8'hFF) ? r_missed : r_missed + 8'd1;

    always_comb begin
        w_nxt_state   = r_state;
        w_nxt_target  = r_target;
        w_nxt_pw      = r_pw;
        w_nxt_dead    = r_dead;
        w_nxt_timeout = r_timeout;
        w_nxt_cnt     = r_cnt;
        w_nxt_to_cnt  = r_to_cnt;
        w_nxt_pulses  = r_pulses;
        w_nxt_missed  = r_missed;
        w_cfg_err     = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                // Abort wins over a simultaneous start.
                if (!i_abort && i_start) begin
                    if (w_cfg_ok) begin
                        w_nxt_target  = i_cfg_target;
                        w_nxt_pw      = i_cfg_pw;
                        w_nxt_dead    = i_cfg_dead;
                        w_nxt_timeout = i_cfg_timeout;
                        w_nxt_pulses  = '0;
                        w_nxt_missed  = '0;
                        w_nxt_to_cnt  = '0;
                        w_nxt_cnt     = '0;
                        w_nxt_state   = S_ARM;
                    end else begin
                        w_cfg_err = 1'b1;
                    end
                end
            end

            S_ARM: begin
                // Any edge seen here is stale driver output and is dropped.
                if (i_abort) begin
                    w_nxt_state = S_IDLE;
                end else begin
                    w_nxt_to_cnt = '0;
                    w_nxt_state  = S_WAIT;
                end
            end

            S_WAIT: begin
                if (i_abort) begin
                    w_nxt_state = S_IDLE;
                end else if (w_rise) begin
                    w_nxt_to_cnt = '0;
                    w_nxt_cnt    = {{(PW_W-1){1'b0}}, 1'b1};
                    w_nxt_state  = S_PULSE;
                end else if ((r_timeout != '0) && (w_to_inc == r_timeout)) begin
                    w_nxt_state = S_FAULT;
                end else begin
                    w_nxt_to_cnt = w_to_inc;
                end
            end

            S_PULSE: begin
                if (i_abort) begin
                    // Truncated pulse is not counted.
                    w_nxt_state = S_IDLE;
                end else begin
                    if (w_rise) begin
                        w_nxt_missed = w_missed_inc;
                    end
                    // r_cnt runs 1..pw; the cycle with r_cnt == pw is the last.
                    if (r_cnt == r_pw) begin
                        w_nxt_pulses = w_pulses_inc;
                        if (w_pulses_inc == r_target) begin
                            w_nxt_state = S_DONE;
                        end else if (r_dead == '0) begin
                            w_nxt_to_cnt = '0;
                            w_nxt_state  = S_WAIT;
                        end else begin
                            w_nxt_cnt   = {{(PW_W-1){1'b0}}, 1'b1};
                            w_nxt_state = S_DEAD;
                        end
                    end else begin
                        w_nxt_cnt = w_cnt_inc;
                    end
                end
            end

            S_DEAD: begin
                if (i_abort) begin
                    w_nxt_state = S_IDLE;
                end else begin
                    if (w_rise) begin
                        w_nxt_missed = w_missed_inc;
                    end
                    if (r_cnt == r_dead) begin
                        w_nxt_to_cnt = '0;
                        w_nxt_state  = S_WAIT;
                    end else begin
                        w_nxt_cnt = w_cnt_inc;
                    end
                end
            end

            S_DONE: begin
                w_nxt_state = S_IDLE;
            end

            S_FAULT: begin
                // Only abort leaves FAULT; start is ignored here.
                if (i_abort) begin
                    w_nxt_state = S_IDLE;
                end
            end

            default: begin
                w_nxt_state = S_IDLE;
            end
        endcase
    end

    assign w_nxt_busy = (w_nxt_state == S_ARM)   ||
                        (w_nxt_state == S_WAIT)  ||
                        (w_nxt_state == S_PULSE) ||
                        (w_nxt_state == S_DEAD);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= S_IDLE;
            r_trig_q       <= 1'b0;
            r_target       <= '0;
            r_pw           <= '0;
            r_dead         <= '0;
            r_timeout      <= '0;
            r_cnt          <= '0;
            r_to_cnt       <= '0;
            r_pulses       <= '0;
            r_missed       <= '0;
            o_drv_en       <= 1'b0;
            o_pulse_out    <= 1'b0;
            o_busy         <= 1'b0;
            o_session_done <= 1'b0;
            o_cfg_err      <= 1'b0;
            o_err_timeout  <= 1'b0;
        end else begin
            r_state        <= w_nxt_state;
            r_trig_q       <= i_trig;
            r_target       <= w_nxt_target;
            r_pw           <= w_nxt_pw;
            r_dead         <= w_nxt_dead;
            r_timeout      <= w_nxt_timeout;
            r_cnt          <= w_nxt_cnt;
            r_to_cnt       <= w_nxt_to_cnt;
            r_pulses       <= w_nxt_pulses;
            r_missed       <= w_nxt_missed;
            // Outputs are decoded from the next state so they line up
            // with the state register and come straight from flops.
            o_drv_en       <= w_nxt_busy;
            o_busy         <= w_nxt_busy;
            o_pulse_out    <= (w_nxt_state == S_PULSE);
            o_session_done <= (w_nxt_state == S_DONE);
            o_err_timeout  <= (w_nxt_state == S_FAULT);
            o_cfg_err      <= w_cfg_err;
        end
    end

    assign o_pulses_sent = r_pulses;
    assign o_missed_trig = r_missed;

endmodule

// File: tb/tb_ire_pulse_sequencer.sv
// tb_ire_pulse_sequencer: directed self-checking bench for ire_pulse_sequencer.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_ire_pulse_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic        trig;
    logic [9:0]  cfg_target;
    logic [15:0] cfg_pw;
    logic [15:0] cfg_dead;
    logic [31:0] cfg_timeout;
    logic        drv_en;
    logic        pulse_out;
    logic        busy;
    logic        session_done;
    logic        cfg_err;
    logic        err_timeout;
    logic [9:0]  pulses_sent;
    logic [7:0]  missed_trig;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ire_pulse_sequencer dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_start        (start),
        .i_abort        (abort),
        .i_trig         (trig),
        .i_cfg_target   (cfg_target),
        .i_cfg_pw       (cfg_pw),
        .i_cfg_dead     (cfg_dead),
        .i_cfg_timeout  (cfg_timeout),
        .o_drv_en       (drv_en),
        .o_pulse_out    (pulse_out),
        .o_busy         (busy),
        .o_session_done (session_done),
        .o_cfg_err      (cfg_err),
        .o_err_timeout  (err_timeout),
        .o_pulses_sent  (pulses_sent),
        .o_missed_trig  (missed_trig)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_sess(input logic [9:0] t, input logic [15:0] p,
                              input logic [15:0] d, input logic [31:0] to,
                              input string tag);
        cfg_target  = t;
        cfg_pw      = p;
        cfg_dead    = d;
        cfg_timeout = to;
        start       = 1'b1;
        cyc(1);
        start = 1'b0;
        chk({tag, "_arm_busy"}, busy, 1);
        chk({tag, "_arm_drv"}, drv_en, 1);
        cyc(1);
        chk({tag, "_wait_pulse"}, pulse_out, 0);
    endtask

    // One-cycle trigger; expects exactly pw high cycles right after it.
    task automatic fire(input int pw, input string tag);
        trig = 1'b1;
        cyc(1);
        trig = 1'b0;
        for (int k = 0; k < pw; k++) begin
            chk({tag, "_hi"}, pulse_out, 1);
            cyc(1);
        end
        chk({tag, "_lo"}, pulse_out, 0);
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        trig        = 1'b0;
        cfg_target  = '0;
        cfg_pw      = '0;
        cfg_dead    = '0;
        cfg_timeout = '0;
        cyc(2);
        chk("rst_drv", drv_en, 0);
        chk("rst_pulse", pulse_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", session_done, 0);
        chk("rst_cfgerr", cfg_err, 0);
        chk("rst_to", err_timeout, 0);
        chk("rst_cnt", pulses_sent, 0);
        chk("rst_miss", missed_trig, 0);
        rst = 1'b0;
        cyc(1);

        // 1: three pulses, start while busy ignored, cfg change ignored
        start_sess(3, 4, 2, 0, "t1");
        cfg_target = 0;
        start      = 1'b1;
        cyc(1);
        start = 1'b0;
        chk("t1_busy_start_err", cfg_err, 0);
        chk("t1_busy_start_busy", busy, 1);
        fire(4, "t1_p1");
        chk("t1_cnt1", pulses_sent, 1);
        chk("t1_dead_drv", drv_en, 1);
        cyc(5);
        fire(4, "t1_p2");
        chk("t1_cnt2", pulses_sent, 2);
        cyc(5);
        fire(4, "t1_p3");
        chk("t1_done", session_done, 1);
        chk("t1_cnt3", pulses_sent, 3);
        chk("t1_miss", missed_trig, 0);
        chk("t1_done_drv", drv_en, 0);
        chk("t1_done_busy", busy, 0);
        cyc(1);
        chk("t1_done_1cyc", session_done, 0);
        chk("t1_hold_cnt", pulses_sent, 3);

        // 2: trigger during pulse is counted as missed
        start_sess(2, 10, 5, 0, "t2");
        chk("t2_cnt_clr", pulses_sent, 0);
        trig = 1'b1;
        cyc(1);
        trig = 1'b0;
        chk("t2_p1_hi", pulse_out, 1);
        cyc(5);
        trig = 1'b1;
        cyc(1);
        trig = 1'b0;
        chk("t2_missed", missed_trig, 1);
        chk("t2_p1_still", pulse_out, 1);
        cyc(23);
        chk("t2_wait_busy", busy, 1);
        chk("t2_wait_pulse", pulse_out, 0);
        chk("t2_cnt1", pulses_sent, 1);
        fire(10, "t2_p2");
        chk("t2_done", session_done, 1);
        chk("t2_cnt2", pulses_sent, 2);
        chk("t2_miss_hold", missed_trig, 1);
        cyc(1);

        // 3: trigger timeout -> FAULT
        start_sess(5, 4, 2, 50, "t3");
        fire(4, "t3_p1");
        cyc(3);
        fire(4, "t3_p2");
        cyc(51);
        chk("t3_pre_to", err_timeout, 0);
        chk("t3_pre_drv", drv_en, 1);
        cyc(1);
        chk("t3_to", err_timeout, 1);
        chk("t3_to_drv", drv_en, 0);
        chk("t3_to_busy", busy, 0);
        chk("t3_to_pulse", pulse_out, 0);
        chk("t3_to_cnt", pulses_sent, 2);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        chk("t3_start_ign", err_timeout, 1);
        chk("t3_start_busy", busy, 0);
        chk("t3_start_err", cfg_err, 0);
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        chk("t3_abort_to", err_timeout, 0);
        chk("t3_abort_busy", busy, 0);
        chk("t3_abort_cnt", pulses_sent, 2);

        // 4: abort in the third cycle of a pulse
        start_sess(3, 8, 2, 0, "t4");
        fire(8, "t4_p1");
        chk("t4_cnt1", pulses_sent, 1);
        cyc(3);
        trig = 1'b1;
        cyc(1);
        trig = 1'b0;
        chk("t4_c1", pulse_out, 1);
        cyc(1);
        chk("t4_c2", pulse_out, 1);
        cyc(1);
        chk("t4_c3", pulse_out, 1);
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        chk("t4_ab_pulse", pulse_out, 0);
        chk("t4_ab_drv", drv_en, 0);
        chk("t4_ab_busy", busy, 0);
        chk("t4_ab_cnt", pulses_sent, 1);
        chk("t4_ab_done", session_done, 0);
        cyc(1);
        chk("t4_ab_done2", session_done, 0);
        chk("t4_ab_busy2", busy, 0);

        // 5: rejected starts and start+abort
        cfg_target = 0;
        cfg_pw     = 4;
        start      = 1'b1;
        cyc(1);
        start = 1'b0;
        chk("t5_tgt0_err", cfg_err, 1);
        chk("t5_tgt0_busy", busy, 0);
        cyc(1);
        chk("t5_tgt0_1cyc", cfg_err, 0);
        cfg_target = 3;
        cfg_pw     = 0;
        start      = 1'b1;
        cyc(1);
        start = 1'b0;
        chk("t5_pw0_err", cfg_err, 1);
        chk("t5_pw0_busy", busy, 0);
        cyc(1);
        chk("t5_pw0_1cyc", cfg_err, 0);
        cfg_pw = 4;
        start  = 1'b1;
        abort  = 1'b1;
        cyc(1);
        start = 1'b0;
        abort = 1'b0;
        chk("t5_sa_busy", busy, 0);
        chk("t5_sa_drv", drv_en, 0);
        chk("t5_sa_err", cfg_err, 0);
        chk("t5_sa_cnt", pulses_sent, 1);
        cyc(1);
        chk("t5_sa_busy2", busy, 0);

        // 6: trig held high before start, dead=0, reset mid-pulse
        trig = 1'b1;
        cyc(2);
        start_sess(2, 3, 0, 0, "t6");
        cyc(4);
        chk("t6_held_pulse", pulse_out, 0);
        chk("t6_held_miss", missed_trig, 0);
        chk("t6_held_busy", busy, 1);
        trig = 1'b0;
        cyc(1);
        chk("t6_fall_pulse", pulse_out, 0);
        fire(3, "t6_p1");
        chk("t6_nodead_busy", busy, 1);
        chk("t6_nodead_drv", drv_en, 1);
        chk("t6_cnt1", pulses_sent, 1);
        trig = 1'b1;
        cyc(1);
        trig = 1'b0;
        chk("t6_p2_hi", pulse_out, 1);
        rst = 1'b1;
        cyc(1);
        chk("t6_rst_pulse", pulse_out, 0);
        chk("t6_rst_drv", drv_en, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_cnt", pulses_sent, 0);
        chk("t6_rst_miss", missed_trig, 0);
        chk("t6_rst_to", err_timeout, 0);
        chk("t6_rst_done", session_done, 0);
        rst = 1'b0;
        cyc(1);
        chk("t6_post_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
